// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding instruction-memory read, held result
// handed to IF/ID, with branch/jump redirect that kills in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifid_write_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc_plus4_out,
    output logic [31:0] instr_out,
    output logic        fetch_valid,
    output logic        bubble_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_imem_req;
    logic [31:0] r_imem_addr;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_fetch_valid;

    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_next;
    logic        w_unused_pc_lsbs;

    assign w_redirect_pc    = {redirect_pc_in[31:2], 2'b00};
    assign w_unused_pc_lsbs = ^redirect_pc_in[1:0];

    // Redirect outranks the sequential advance, whatever the state.
    always_comb begin
        w_pc_next = r_pc;
        if (redirect_in)
            w_pc_next = w_redirect_pc;
        else if (r_state == S_HOLD && ifid_write_in)
            w_pc_next = r_pc + 32'd4;
    end

    // Request and address are registered on entry to S_REQ, so a redirect taken
    // while in S_REQ cannot disturb the address already on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= 32'h0;
            r_instr       <= 32'h0;
            r_pc_plus4    <= 32'h0;
            r_fetch_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere here so every register sees the
            // pre-edge value of its peers; blocking would create ordering bugs.
            r_pc       <= w_pc_next;
            r_imem_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_REQ;
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_pc_next;
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                    if (redirect_in)
                        r_kill <= 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid && (redirect_in || r_kill)) begin
                        r_kill      <= 1'b0;
                        r_state     <= S_REQ;
                        r_imem_req  <= 1'b1;
                        r_imem_addr <= w_pc_next;
                    end else if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_pc_plus4    <= r_pc + 32'd4;
                        r_fetch_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end else if (redirect_in) begin
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_in || ifid_write_in) begin
                        r_fetch_valid <= 1'b0;
                        r_state       <= S_REQ;
                        r_imem_req    <= 1'b1;
                        r_imem_addr   <= w_pc_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_imem_addr;
    assign instr_out    = r_instr;
    assign pc_plus4_out = r_pc_plus4;
    assign fetch_valid  = r_fetch_valid;
    assign bubble_out   = redirect_in | (~r_fetch_valid & ifid_write_in);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable instruction memory
// model driven from the stimulus thread.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifid_write_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        fetch_valid;
    logic        bubble_out;

    int n_cmp = 0;
    int n_err = 0;

    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ifid_write_in  (ifid_write_in),
        .redirect_in    (redirect_in),
        .redirect_pc_in (redirect_pc_in),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .pc_plus4_out   (pc_plus4_out),
        .instr_out      (instr_out),
        .fetch_valid    (fetch_valid),
        .bubble_out     (bubble_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the memory latches the request visible before the edge and
    // raises rvalid for one cycle once its latency has elapsed.
    task automatic step();
        logic        r;
        logic [31:0] a;
        r = imem_req;
        a = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (r) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = a;
        end
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem(paddr);
                pend        = 1'b0;
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        ifid_write_in  = 1'b0;
        redirect_in    = 1'b0;
        redirect_pc_in = 32'h0;
        imem_rdata     = 32'h0;
        imem_rvalid    = 1'b0;
        repeat (3) step();

        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc4", pc_plus4_out, 32'h0);
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_bubble", {31'b0, bubble_out}, 32'h0);

        // Basic fetch from RESET_PC with a 1-cycle memory.
        reset = 1'b0;
        ifid_write_in = 1'b1;
        step();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("bubble_empty", {31'b0, bubble_out}, 32'h1);
        step();
        chk("wait_req", {31'b0, imem_req}, 32'h0);
        chk("wait_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("f0_valid", {31'b0, fetch_valid}, 32'h1);
        chk("f0_instr", instr_out, 32'h0000_0013);
        chk("f0_pc4", pc_plus4_out, 32'h4);
        chk("f0_bubble", {31'b0, bubble_out}, 32'h0);
        step();
        chk("f1_addr", imem_addr, 32'h4);
        chk("f1_req", {31'b0, imem_req}, 32'h1);
        step();
        step();
        chk("f1_instr", instr_out, 32'h0000_0413);
        step();
        chk("f2_addr", imem_addr, 32'h8);
        step();
        step();
        ifid_write_in = 1'b0;

        // Stall with the pc=8 instruction held.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", {31'b0, fetch_valid}, 32'h1);
            chk("stall_instr", instr_out, 32'h0000_0813);
            chk("stall_pc4", pc_plus4_out, 32'hC);
            chk("stall_req", {31'b0, imem_req}, 32'h0);
            chk("stall_bubble", {31'b0, bubble_out}, 32'h0);
            step();
        end
        ifid_write_in = 1'b1;
        step();
        chk("after_stall_addr", imem_addr, 32'hC);

        // Redirect during WAIT with a slow memory: stale data must be dropped.
        lat = 3;
        step();
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h0000_0103;
        #1;
        chk("redir_wait_bubble", {31'b0, bubble_out}, 32'h1);
        step();
        redirect_in = 1'b0;
        chk("redir_wait_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("redir_wait_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        chk("stale_valid", {31'b0, fetch_valid}, 32'h0);
        chk("stale_req", {31'b0, imem_req}, 32'h1);
        chk("stale_addr", imem_addr, 32'h100);
        chk("stale_instr", instr_out, 32'h0000_0813);

        // Redirect coincident with the response.
        lat = 1;
        step();
        ifid_write_in  = 1'b0;
        redirect_in    = 1'b1;
        redirect_pc_in = 32'h40;
        #1;
        chk("coinc_rvalid", {31'b0, imem_rvalid}, 32'h1);
        chk("coinc_bubble", {31'b0, bubble_out}, 32'h1);
        step();
        redirect_in = 1'b0;
        #1;
        chk("coinc_req", {31'b0, imem_req}, 32'h1);
        chk("coinc_addr", imem_addr, 32'h40);
        chk("coinc_valid", {31'b0, fetch_valid}, 32'h0);
        chk("coinc_instr", instr_out, 32'h0000_0813);
        chk("idle_bubble", {31'b0, bubble_out}, 32'h0);
        step();
        step();
        chk("f40_instr", instr_out, 32'h0000_4013);
        chk("f40_pc4", pc_plus4_out, 32'h44);

        // Redirect in HOLD to the top word; low target bits are ignored.
        redirect_in    = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFF;
        step();
        redirect_in   = 1'b0;
        ifid_write_in = 1'b1;
        chk("hold_redir_valid", {31'b0, fetch_valid}, 32'h0);
        chk("hold_redir_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        step();
        chk("wrap_valid", {31'b0, fetch_valid}, 32'h1);
        chk("wrap_instr", instr_out, 32'hFFFF_FC13);
        chk("wrap_pc4", pc_plus4_out, 32'h0);
        step();
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset mid-WAIT; the late response lands while in REQ and is ignored.
        lat = 3;
        step();
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        chk("arst_instr", instr_out, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("restart_req", {31'b0, imem_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("late_rvalid", {31'b0, imem_rvalid}, 32'h1);
        step();
        chk("late_ignored", {31'b0, fetch_valid}, 32'h0);
        step();
        step();
        step();
        chk("restart_valid", {31'b0, fetch_valid}, 32'h1);
        chk("restart_instr", instr_out, 32'h0000_0013);
        chk("restart_pc4", pc_plus4_out, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
